// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter lookup table, default widths and
// the sequencer index width used by the triangle channel.
package apu_pkg;

  localparam int TIMER_W_DEF = 11;
  localparam int LEN_W_DEF   = 8;
  localparam int SEQ_W       = 5;
  localparam int LIN_W       = 7;

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    return LENGTH_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// APU length counter: table load on register write, half-frame decrement
// unless halted, forced to zero while the channel is disabled.
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [4:0]       load_idx,
  input  logic             half_frame,
  input  logic             halt,
  input  logic             en,
  output logic [LEN_W-1:0] length
);

  // Disable beats load, load beats the half-frame decrement; saturates at 0.
  always_ff @(posedge clk) begin
    if (reset)
      length <= '0;
    else if (!en)
      length <= '0;
    else if (load)
      length <= LEN_W'(length_lookup(load_idx));
    else if (half_frame && !halt && length != '0)
      length <= length - LEN_W'(1);
  end

endmodule

// File: rtl/triangle_channel.sv
// NES-style triangle channel: period timer, 32-step sequencer, linear
// counter and length counter gating.
// Optional macro TRI_ULTRASONIC_MUTE_EN: freezes the sequencer while
// period < 2 to avoid ultrasonic output.
module triangle_channel
  import apu_pkg::*;
#(
  parameter int TIMER_W = TIMER_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quarter_frame,
  input  logic       half_frame,
  input  logic [7:0] reg4008,
  input  logic [7:0] reg400a,
  input  logic [7:0] reg400b,
  input  logic       reg400b_wr,
  input  logic       length_en,
  output logic [3:0] wave
);

  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] timer;
  logic [SEQ_W-1:0]   seq_idx;
  logic [LIN_W-1:0]   linear;
  logic               reload_flag;
  logic [LEN_W-1:0]   length;
  logic               control;
  logic               freq_ok;
  logic               step;
  logic               reload_now;

  assign control = reg4008[7];
  assign period  = TIMER_W'({reg400b[2:0], reg400a});

`ifdef TRI_ULTRASONIC_MUTE_EN
  assign freq_ok = (period >= TIMER_W'(2));
`else
  assign freq_ok = 1'b1;
`endif

  assign step = (timer == '0) && (linear != '0) && (length != '0) && freq_ok;

  // A write landing on the same quarter-frame already performs the reload.
  assign reload_now = reload_flag || reg400b_wr;

  // Period timer; a new period only takes effect at the next reload.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (timer == '0)
      timer <= period;
    else
      timer <= timer - TIMER_W'(1);
  end

  // Sequencer index, wraps 31 -> 0 and holds while gated.
  always_ff @(posedge clk) begin
    if (reset)
      seq_idx <= '0;
    else if (step)
      seq_idx <= seq_idx + SEQ_W'(1);
  end

  // Linear counter clocked by the quarter-frame strobe.
  always_ff @(posedge clk) begin
    if (reset)
      linear <= '0;
    else if (quarter_frame) begin
      if (reload_now)
        linear <= reg4008[6:0];
      else if (linear != '0)
        linear <= linear - LIN_W'(1);
    end
  end

  // Reload flag: set by a $400B write, which wins over the quarter-frame clear.
  always_ff @(posedge clk) begin
    if (reset)
      reload_flag <= 1'b0;
    else if (reg400b_wr)
      reload_flag <= 1'b1;
    else if (quarter_frame && !control)
      reload_flag <= 1'b0;
  end

  apu_length_counter #(.LEN_W(LEN_W)) u_len (
    .clk        (clk),
    .reset      (reset),
    .load       (reg400b_wr),
    .load_idx   (reg400b[7:3]),
    .half_frame (half_frame),
    .halt       (control),
    .en         (length_en),
    .length     (length)
  );

  // Down ramp 15..0 for idx 0..15, up ramp 0..15 for idx 16..31.
  assign wave = seq_idx[4] ? seq_idx[3:0] : ~seq_idx[3:0];

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel: reset, tone stepping, linear and
// length gating, enable clear, write/half-frame collision, low-period mute.
module tb_triangle_channel;

  logic       clk = 1'b0;
  logic       reset;
  logic       quarter_frame, half_frame, reg400b_wr, length_en;
  logic [7:0] reg4008, reg400a, reg400b;
  logic [3:0] wave;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  triangle_channel dut (
    .clk           (clk),
    .reset         (reset),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .reg4008       (reg4008),
    .reg400a       (reg400a),
    .reg400b       (reg400b),
    .reg400b_wr    (reg400b_wr),
    .length_en     (length_en),
    .wave          (wave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int wave_of(input int idx);
    return (idx < 16) ? 15 - idx : idx - 16;
  endfunction

  task automatic wr400b(input logic [7:0] v, input logic qf, input logic hf);
    reg400b = v; reg400b_wr = 1'b1; quarter_frame = qf; half_frame = hf;
    tick();
    reg400b_wr = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
  endtask

  task automatic qf_pulse();
    quarter_frame = 1'b1; tick(); quarter_frame = 1'b0; tick(2);
  endtask

  task automatic hf_pulse();
    half_frame = 1'b1; tick(); half_frame = 1'b0; tick(2);
  endtask

  initial begin
    int idx0, w0, n;
    reset = 1'b1; quarter_frame = 0; half_frame = 0; reg400b_wr = 0;
    length_en = 0; reg4008 = 0; reg400a = 0; reg400b = 0;
    @(negedge clk);
    tick(2);
    chk("rst_wave",   wave, 15);
    chk("rst_length", dut.length, 0);
    chk("rst_linear", dut.linear, 0);
    chk("rst_timer",  dut.timer, 0);
    reset = 1'b0;
    tick(20);
    chk("idle_idx",  dut.seq_idx, 0);
    chk("idle_wave", wave, 15);

    // Basic tone: period 10 -> one step every 11 clocks.
    length_en = 1; reg4008 = 8'hE4; reg400a = 8'd10;
    wr400b({5'd22, 3'd0}, 1'b0, 1'b0);
    chk("tone_length", dut.length, 96);
    quarter_frame = 1'b1; tick(); quarter_frame = 1'b0;
    chk("tone_linear", dut.linear, 100);
    n = 0;
    while (dut.seq_idx == 0 && n < 40) begin tick(); n++; end
    chk("tone_first_idx", dut.seq_idx, 1);
    chk("tone_first_wave", wave, 14);
    for (int k = 1; k <= 32; k++) begin
      tick(10);
      chk("tone_hold", dut.seq_idx, (k) % 32);
      tick(1);
      chk("tone_idx",  dut.seq_idx, (1 + k) % 32);
      chk("tone_wave", wave, wave_of((1 + k) % 32));
    end

    // Linear gating: reload 3 with control clear, then count down.
    reg4008 = 8'h03;
    wr400b({5'd22, 3'd0}, 1'b0, 1'b0);
    qf_pulse(); chk("lin_3", dut.linear, 3);
    qf_pulse(); chk("lin_2", dut.linear, 2);
    qf_pulse(); chk("lin_1", dut.linear, 1);
    qf_pulse(); chk("lin_0", dut.linear, 0);
    idx0 = dut.seq_idx; w0 = wave;
    tick(30);
    chk("lin_hold_idx",  dut.seq_idx, idx0);
    chk("lin_hold_wave", wave, w0);

    // Length halt, with write coincident with quarter_frame reloading linear.
    reg4008 = 8'hFF;
    wr400b({5'd3, 3'd0}, 1'b1, 1'b0);
    chk("qf_coinc_linear", dut.linear, 127);
    chk("len_load2", dut.length, 2);
    for (int i = 0; i < 5; i++) hf_pulse();
    chk("len_halted", dut.length, 2);
    reg4008 = 8'h7F;
    hf_pulse(); chk("len_1", dut.length, 1);
    hf_pulse(); chk("len_0", dut.length, 0);
    idx0 = dut.seq_idx;
    tick(30);
    chk("len_gate_idx", dut.seq_idx, idx0);

    // Channel disable clears and blocks loads.
    reg4008 = 8'h80;
    wr400b({5'd1, 3'd0}, 1'b0, 1'b0);
    chk("en_load254", dut.length, 254);
    length_en = 0; tick();
    chk("en_clear", dut.length, 0);
    wr400b({5'd1, 3'd0}, 1'b0, 1'b0);
    chk("en_blocked", dut.length, 0);

    // Write coincident with half_frame: table value, no decrement.
    length_en = 1; reg4008 = 8'h00;
    wr400b({5'd1, 3'd0}, 1'b0, 1'b0);
    chk("coll_pre", dut.length, 254);
    wr400b({5'd22, 3'd0}, 1'b0, 1'b1);
    chk("coll_len", dut.length, 96);

    // Period 1: frozen with mute, else one step per 2 clocks.
    reg4008 = 8'hC0; reg400a = 8'd1;
    wr400b({5'd22, 3'd0}, 1'b1, 1'b0);
    chk("mute_linear", dut.linear, 64);
    tick(12);
    idx0 = dut.seq_idx;
    tick(10);
`ifdef TRI_ULTRASONIC_MUTE_EN
    chk("mute_frozen", dut.seq_idx, idx0);
`else
    chk("p1_step", dut.seq_idx, (idx0 + 5) % 32);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/triangle_channel.md
Name: triangle_channel

Overview:
- NES-APU-style triangle wave generator: 11-bit period timer, 32-step sequencer, linear counter and length counter gating.
- Sits in the APU beside the pulse and noise channels.
- Fed by the frame sequencer's quarter-frame and half-frame strobes and by the CPU register bytes $4008/$400A/$400B.
- Outputs a 4-bit sample to the mixer.

Parameters:
- TIMER_W, 11, timer/period width.
- LEN_W, 8, length counter width.

Ports:
- clk  input  1  single system clock; timer decrements once per clk.
- reset  input  1  synchronous, active-high.
- quarter_frame  input  1  one-cycle strobe; clocks the linear counter.
- half_frame  input  1  one-cycle strobe; clocks the length counter.
- reg4008  input  8  [7] control/halt flag, [6:0] linear reload value.
- reg400a  input  8  period[7:0].
- reg400b  input  8  [7:3] length-table index, [2:0] period[10:8].
- reg400b_wr  input  1  one-cycle strobe: CPU wrote $400B this cycle.
- length_en  input  1  channel enable ($4015 bit 2).
- wave  output  4  current sequencer sample.

Behaviour:
- Reset (synchronous): timer=0, seq_idx=0, linear=0, reload_flag=0, length=0, wave=15.
- Register inputs are levels, sampled every cycle.
- period = {reg400b[2:0], reg400a}.
- Timer, every clk:
  - if timer==0: timer<=period, and seq_idx advances when linear!=0 && length!=0;
  - else timer<=timer-1.
  - Step interval = period+1 clocks.
- Sequencer:
  - seq_idx 5 bits, wraps 31->0.
  - wave = 15-seq_idx for idx 0..15; seq_idx-16 for idx 16..31.
  - Sequence is 15,14..0,0,1..15.
  - When gated, wave holds its last value; it never forces 0.
- Linear counter (7-bit), on quarter_frame:
  - if reload_flag: linear<=reg4008[6:0];
  - else if linear!=0: linear<=linear-1.
  - Then, if reg4008[7]==0: reload_flag<=0.
- reload_flag set by reg400b_wr:
  - set takes priority over the clear in the same cycle;
  - a quarter_frame coincident with the write performs the reload.
- Length counter (LEN_W bits):
  - on reg400b_wr with length_en=1: length<=LENGTH_TABLE[reg400b[7:3]];
  - otherwise on half_frame: if reg4008[7]==0 && length!=0, length<=length-1;
  - length_en==0 forces length<=0 every cycle;
  - a write coinciding with half_frame wins (no decrement).
- LENGTH_TABLE[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Counter wrap: none; all counters saturate at 0.
- Period change mid-count takes effect at the next reload.

Optional Feature:
- Macro: TRI_ULTRASONIC_MUTE_EN.
- Defined: when period<2, sequencer stepping is inhibited (seq_idx holds), avoiding ultrasonic popping.
- Undefined: period 0/1 step normally every 1/2 clocks whenever gating allows.

Decomposition:
- Package apu_pkg: LENGTH_TABLE constant array, TIMER_W/LEN_W defaults, seq_idx width constant.
- One natural sub-module, apu_length_counter:
  - holds load, half_frame decrement, halt and enable-clear;
  - reused by the pulse and noise channels.
- Linear counter, timer and sequencer stay inline.

Test Plan:
- Reset: assert reset 2 cycles -> wave=15, length=0, linear=0, no stepping afterwards without a write.
- Basic tone: reg4008=0xE4 (control=1, reload=100), period=10, reg400b index 22, pulse reg400b_wr, length_en=1, then quarter_frame -> length=96, linear=100; wave steps every 11 clk: 15,14,…,0,0,1,…,15; full cycle 352 clk.
- Linear gating: control=0, reload=3, four quarter_frame strobes after the write -> linear 3,2,1,0; stepping stops; wave holds its last value.
- Length gating with halt: control=1, index 3 (length=2), 5 half_frames -> length stays 2. Then control=0, 2 half_frames -> length 0, stepping stops.
- length_en low: load index 1 -> length 254; drop length_en -> length=0 next cycle. Write with length_en=0 -> length stays 0.
- Collisions and mute:
  - reg400b_wr coincident with half_frame -> length equals the table value, undecremented.
  - With TRI_ULTRASONIC_MUTE_EN defined, period=1 -> seq_idx frozen.
